// File: rtl/ram_block_mover_pkg.sv
// Shared types and default sizes for the RAM block mover.
package ram_block_mover_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_FILL = 3'd4
    } state_e;

    typedef enum logic {
        DIR_ASC  = 1'b0,
        DIR_DESC = 1'b1
    } dir_e;

endpackage

// File: rtl/ram_block_mover_addr_step.sv
// Pointer stepper: moves an address one word up or down, wrapping modulo 2^ADDR_W.
module ram_addr_step
    import ram_block_mover_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] ptr_i,
    input  dir_e              dir_i,
    output logic [ADDR_W-1:0] ptr_o
);

    // Select increment or decrement; natural overflow gives the wrap.
    always_comb begin
        if (dir_i == DIR_DESC) begin
            ptr_o = ptr_i - ADDR_W'(1);
        end else begin
            ptr_o = ptr_i + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/ram_block_mover.sv
// Copies a block of words inside one RAM address space, choosing direction for overlaps.
// Optional fill mode is built when RAM_BLOCK_MOVER_FILL_EN is defined.
module ram_block_mover
    import ram_block_mover_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
`ifdef RAM_BLOCK_MOVER_FILL_EN
    input  logic              mode,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(1) << ADDR_W;

    state_e              state_q, state_d;
    dir_e                dir_q, dir_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d, rd_ptr_nx_s;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, wr_ptr_nx_s;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W:0]     len_sat_s;
    logic [ADDR_W-1:0]   diff_s, off_s;
`ifdef RAM_BLOCK_MOVER_FILL_EN
    logic [DATA_W-1:0]   fill_q, fill_d;
`endif

    logic                busy_d, done_d, load_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   in_d;

    ram_addr_step #(.ADDR_W(ADDR_W)) u_rd_step (
        .ptr_i (rd_ptr_q),
        .dir_i (dir_q),
        .ptr_o (rd_ptr_nx_s)
    );

    ram_addr_step #(.ADDR_W(ADDR_W)) u_wr_step (
        .ptr_i (wr_ptr_q),
        .dir_i (dir_q),
        .ptr_o (wr_ptr_nx_s)
    );

    // Next-state, pointer and count logic.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
`ifdef RAM_BLOCK_MOVER_FILL_EN
        fill_d   = fill_q;
`endif
        len_sat_s = (len > LEN_MAX) ? LEN_MAX : len;
        diff_s    = dst - src;
        // Low bits of a saturated full-space length are zero, so minus one still wraps to the last word.
        off_s     = len_sat_s[ADDR_W-1:0] - ADDR_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = len_sat_s;
`ifdef RAM_BLOCK_MOVER_FILL_EN
                    fill_d = fill_value;
`endif
                    if (len_sat_s == {(ADDR_W+1){1'b0}}) begin
                        state_d = ST_DONE;
`ifdef RAM_BLOCK_MOVER_FILL_EN
                    end else if (mode) begin
                        state_d  = ST_FILL;
                        dir_d    = DIR_ASC;
                        wr_ptr_d = dst;
`endif
                    end else if (dst == src) begin
                        state_d = ST_DONE;
                    end else if ({1'b0, diff_s} < len_sat_s) begin
                        state_d  = ST_RD;
                        dir_d    = DIR_DESC;
                        rd_ptr_d = src + off_s;
                        wr_ptr_d = dst + off_s;
                    end else begin
                        state_d  = ST_RD;
                        dir_d    = DIR_ASC;
                        rd_ptr_d = src;
                        wr_ptr_d = dst;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                data_d  = mem_out;
                state_d = ST_WR;
            end
            ST_WR: begin
                rd_ptr_d = rd_ptr_nx_s;
                wr_ptr_d = wr_ptr_nx_s;
                cnt_d    = cnt_q - (ADDR_W+1)'(1);
                if (cnt_q == (ADDR_W+1)'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RD;
                end
            end
`ifdef RAM_BLOCK_MOVER_FILL_EN
            ST_FILL: begin
                wr_ptr_d = wr_ptr_nx_s;
                cnt_d    = cnt_q - (ADDR_W+1)'(1);
                if (cnt_q == (ADDR_W+1)'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FILL;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from next state so they can be registered with no added latency.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        addr_d = {ADDR_W{1'b0}};
        in_d   = {DATA_W{1'b0}};
        load_d = 1'b0;
        case (state_d)
            ST_RD: begin
                addr_d = rd_ptr_d;
            end
            ST_WR: begin
                addr_d = wr_ptr_d;
                in_d   = data_d;
                load_d = 1'b1;
            end
`ifdef RAM_BLOCK_MOVER_FILL_EN
            ST_FILL: begin
                addr_d = wr_ptr_d;
                in_d   = fill_d;
                load_d = 1'b1;
            end
`endif
            default: begin
                load_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_ASC;
            rd_ptr_q    <= {ADDR_W{1'b0}};
            wr_ptr_q    <= {ADDR_W{1'b0}};
            cnt_q       <= {(ADDR_W+1){1'b0}};
            data_q      <= {DATA_W{1'b0}};
`ifdef RAM_BLOCK_MOVER_FILL_EN
            fill_q      <= {DATA_W{1'b0}};
`endif
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_address <= {ADDR_W{1'b0}};
            mem_in      <= {DATA_W{1'b0}};
            mem_load    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
`ifdef RAM_BLOCK_MOVER_FILL_EN
            fill_q      <= fill_d;
`endif
            busy        <= busy_d;
            done        <= done_d;
            mem_address <= addr_d;
            mem_in      <= in_d;
            mem_load    <= load_d;
        end
    end

endmodule
